// File: rtl/cntrl_pkg.sv
// Shared definitions for the frame loader: FSM states, frame geometry and field layout.
// Both the loader (encoder side) and frame consumers (decoder side) import this package.
package cntrl_pkg;

  localparam int unsigned FRAME_W    = 17;
  localparam int unsigned NUM_FRAMES = 6;
  localparam int unsigned ADDR_W     = 3;
  localparam logic [2:0]  LAST_ADDR  = 3'b101;

  // Field bit positions inside an assembled frame
  localparam int unsigned A_MSB   = 16;
  localparam int unsigned A_LSB   = 13;
  localparam int unsigned B_MSB   = 12;
  localparam int unsigned B_LSB   = 9;
  localparam int unsigned C_BIT   = 8;
  localparam int unsigned OP_MSB  = 7;
  localparam int unsigned OP_LSB  = 4;
  localparam int unsigned EXP_MSB = 3;
  localparam int unsigned EXP_LSB = 0;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_SHIFT = 4'b0010,
    ST_WRITE = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] op_code;
    logic [3:0] exp;
  } frame_t;

  function automatic frame_t unpack_frame(input logic [FRAME_W-1:0] f);
    frame_t r;
    r.a       = f[A_MSB:A_LSB];
    r.b       = f[B_MSB:B_LSB];
    r.c       = f[C_BIT];
    r.op_code = f[OP_MSB:OP_LSB];
    r.exp     = f[EXP_MSB:EXP_LSB];
    return r;
  endfunction

endpackage

// File: rtl/frame_loader_if.sv
// Serial-in handshake and frame-memory write bus of the frame loader.
// master = loader side, slave = serial source / memory side.
interface frame_loader_if #(
  parameter int unsigned FRAME_W = cntrl_pkg::FRAME_W,
  parameter int unsigned ADDR_W  = cntrl_pkg::ADDR_W
);
  logic               ser_valid;
  logic               ser_data;
  logic               ser_ready;
  logic               mem_wr_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic [FRAME_W-1:0] mem_wr_data;

  modport master (
    input  ser_valid, ser_data,
    output ser_ready, mem_wr_en, mem_addr, mem_wr_data
  );

  modport slave (
    output ser_valid, ser_data,
    input  ser_ready, mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/frame_shifter.sv
// Serial-in, MSB-first shift register with accepted-bit counter.
// full flags the cycle in which the last bit of a frame is being accepted.
module frame_shifter #(
  parameter int unsigned FRAME_W = cntrl_pkg::FRAME_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               shift_en,
  input  logic               ser_data,
  output logic [FRAME_W-1:0] frame,
  output logic               full
);
  localparam int unsigned CNT_W = $clog2(FRAME_W + 1);

  logic [CNT_W-1:0] bit_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      frame   <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      frame   <= {frame[FRAME_W-2:0], ser_data};
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  assign full = shift_en && (bit_cnt == CNT_W'(FRAME_W - 1));

endmodule

// File: rtl/frame_loader.sv
// Loads NUM_FRAMES serially received frames into frame memory at addresses 0..NUM_FRAMES-1,
// then holds load_done until the next start.
module frame_loader import cntrl_pkg::*; #(
  parameter int unsigned FRAME_W    = cntrl_pkg::FRAME_W,
  parameter int unsigned NUM_FRAMES = cntrl_pkg::NUM_FRAMES,
  parameter int unsigned ADDR_W     = cntrl_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  frame_loader_if.master    bus,
  output logic [ADDR_W-1:0] frame_cnt,
  output logic              busy,
  output logic              load_done
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_FRAMES - 1);

  state_t             state, state_n;
  logic               shift_en, clear_bits, full, restart;
  logic [FRAME_W-1:0] frame, held_data;
  logic [ADDR_W-1:0]  addr;

  assign restart  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign shift_en = (state == ST_SHIFT) && bus.ser_valid;

  frame_shifter #(.FRAME_W(FRAME_W)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear_bits),
    .shift_en (shift_en),
    .ser_data (bus.ser_data),
    .frame    (frame),
    .full     (full)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    clear_bits = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n    = ST_SHIFT;
          clear_bits = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (full) state_n = ST_WRITE;
      end
      ST_WRITE: begin
        clear_bits = 1'b1;
        state_n    = (addr == LAST) ? ST_DONE : ST_SHIFT;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Address saturates at LAST; held_data keeps the written frame visible after WRITE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr      <= '0;
      frame_cnt <= '0;
      held_data <= '0;
    end else if (restart) begin
      addr      <= '0;
      frame_cnt <= '0;
    end else if (state == ST_WRITE) begin
      frame_cnt <= frame_cnt + ADDR_W'(1);
      held_data <= frame;
      if (addr != LAST) addr <= addr + ADDR_W'(1);
    end
  end

  assign bus.ser_ready   = (state == ST_SHIFT);
  assign bus.mem_wr_en   = (state == ST_WRITE);
  assign bus.mem_addr    = addr;
  assign bus.mem_wr_data = (state == ST_WRITE) ? frame : held_data;
  assign busy            = (state == ST_SHIFT) || (state == ST_WRITE);
  assign load_done       = (state == ST_DONE);

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader: cycle table for the first frames, hand sequences
// for reset/restart corners, and randomized loads checked against an expected-write queue.
module tb_frame_loader;
  import cntrl_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] frame_cnt;
  logic       busy;
  logic       load_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_on = 1'b0;

  frame_loader_if bus ();

  frame_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .frame_cnt (frame_cnt),
    .busy      (busy),
    .load_done (load_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic        s, v, d;
    logic [26:0] exp;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [2:0]  addr;
    logic [16:0] data;
  } wr_t;

  vec_t tbl[$];
  wr_t  expq[$];

  function automatic logic [26:0] pk(input logic rdy, bsy, dn, we,
                                     input logic [2:0] a, c, input logic [16:0] wd);
    return {rdy, bsy, dn, we, a, c, wd};
  endfunction

  task automatic add(input string nm, input logic s, v, d, input logic [26:0] e);
    vec_t r;
    r.name = nm; r.s = s; r.v = v; r.d = d; r.exp = e;
    tbl.push_back(r);
  endtask

  task automatic step(input logic s, v, d);
    start = s; bus.ser_valid = v; bus.ser_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [26:0] e);
    logic [26:0] act;
    act = {bus.ser_ready, busy, load_done, bus.mem_wr_en, bus.mem_addr, frame_cnt, bus.mem_wr_data};
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL %s: got {rdy,busy,done,we,addr,cnt,data}=%h want %h", nm, act, e);
    end
  endtask

  task automatic chk_empty(input string nm);
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL %s: %0d expected writes never seen, want 0", nm, expq.size());
      expq.delete();
    end
  endtask

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // Drives one frame MSB first; the write is due in the cycle after the last bit.
  task automatic send_frame(input logic [16:0] f, input logic [2:0] a, input bit rnd);
    wr_t e;
    for (int i = 16; i >= 0; i--) begin
      if (rnd) repeat ($urandom_range(0, 2)) step(rb(), 1'b0, rb());
      step(rnd ? rb() : 1'b0, 1'b1, f[i]);
    end
    e.cyc = cyc; e.addr = a; e.data = f;
    expq.push_back(e);
    step(rnd ? rb() : 1'b0, rnd ? rb() : 1'b1, rb());
  endtask

  // Reference model: every observed write must match the next expected one exactly.
  always @(negedge clk) begin
    if (mon_on && bus.mem_wr_en === 1'b1) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL spurious_write: got addr=%0d data=%h at cycle %0d, want no write",
                 bus.mem_addr, bus.mem_wr_data, cyc);
      end else begin
        wr_t e;
        e = expq.pop_front();
        if (e.cyc != cyc || e.addr !== bus.mem_addr || e.data !== bus.mem_wr_data) begin
          bad++;
          $display("FAIL write: got cyc=%0d addr=%0d data=%h want cyc=%0d addr=%0d data=%h",
                   cyc, bus.mem_addr, bus.mem_wr_data, e.cyc, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    logic [16:0] F, last_f;
    logic [3:0]  fa, fb, fop, fex;
    logic        fc;
    frame_t      fr;

    reset = 1'b0; start = 1'b0; bus.ser_valid = 1'b0; bus.ser_data = 1'b0;
    F = 17'h12725;

    // Table: frame 0 continuous with start at bit 8, frame 1 with ser_valid toggling
    add("start", 1, 0, 0, pk(1, 1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 17; i++)
      add(i == 16 ? "f0_write" : "f0_bit", i == 8, 1, F[16-i],
          i == 16 ? pk(0, 1, 0, 1, 0, 0, F) : pk(1, 1, 0, 0, 0, 0, 0));
    add("f1_shift", 0, 0, 0, pk(1, 1, 0, 0, 1, 1, F));
    for (int j = 0; j < 34; j++) begin
      int k;
      k = j / 2;
      if (j == 32)      add("f1_write", 0, 1, F[16-k], pk(0, 1, 0, 1, 1, 1, F));
      else if (j == 33) add("f2_shift", 0, 0, ~F[16-k], pk(1, 1, 0, 0, 2, 2, F));
      else if (j % 2 == 0) add("f1_bit", 0, 1, F[16-k], pk(1, 1, 0, 0, 1, 1, F));
      else                 add("f1_gap", 0, 0, ~F[16-k], pk(1, 1, 0, 0, 1, 1, F));
    end

    // Reset dominates start and ser_valid
    step(1, 1, 1);
    step(1, 1, 1);
    chk("reset", pk(0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    step(0, 1, 1);
    chk("idle_ignores_valid", pk(0, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0);

    foreach (tbl[n]) begin
      step(tbl[n].s, tbl[n].v, tbl[n].d);
      chk(tbl[n].name, tbl[n].exp);
      if (tbl[n].name == "f0_write") begin
        fr = unpack_frame(bus.mem_wr_data);
        fa = fr.a; fb = fr.b; fc = fr.c; fop = fr.op_code; fex = fr.exp;
        total++;
        if ({fa, fb, fc, fop, fex} !== {4'd9, 4'd3, 1'b1, 4'd2, 4'd5}) begin
          bad++;
          $display("FAIL fields: got a=%0d b=%0d c=%0d op=%0d exp=%0d want 9 3 1 2 5",
                   fa, fb, fc, fop, fex);
        end
      end
    end

    // Reset after 10 bits of frame 2 discards it
    mon_on = 1'b1;
    for (int i = 0; i < 10; i++) step(0, 1, rb());
    reset = 1'b0;
    step(0, 1, 1);
    chk("reset_mid_shift", pk(0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    step(0, 1, 1);
    chk("idle_after_reset", pk(0, 0, 0, 0, 0, 0, 0));

    // Six back-to-back frames
    step(1, 0, 0);
    for (int k = 0; k < 6; k++) send_frame(17'(k + 1), 3'(k), 1'b0);
    chk("done_after_6", pk(0, 0, 1, 0, 5, 6, 17'h00006));
    for (int i = 0; i < 3; i++) step(0, 1, rb());
    chk("done_holds", pk(0, 0, 1, 0, 5, 6, 17'h00006));
    chk_empty("missing_write_seq6");

    // Start in DONE restarts from address 0
    step(1, 0, 0);
    chk("restart_from_done", pk(1, 1, 0, 0, 0, 0, 17'h00006));

    last_f = '0;
    for (int n = 0; n < 4; n++) begin
      if (n > 0) step(1, 0, 0);
      for (int k = 0; k < 6; k++) begin
        F = 17'($urandom_range(0, 17'h1FFFF));
        send_frame(F, 3'(k), 1'b1);
        last_f = F;
      end
      chk("rand_done", pk(0, 0, 1, 0, 5, 6, last_f));
      chk_empty("missing_write_rand");
    end

    step(0, 1, 1);
    step(0, 0, 0);
    chk_empty("missing_write_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
